// File: rtl/noc_params.sv
// rtl/noc_params.sv - shared NoC flit types and virtual-channel sizing
// Purpose: flit label encoding, flit structs with and without VC id, VC count/width.
// Ports: none (package).
package noc_params;

    localparam int VC_NUM     = 2;
    localparam int VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t            flit_label;
        logic [VC_SIZE-1:0]     vc_id;
        logic [DATA_WIDTH-1:0]  data;
    } flit_t;

    typedef struct packed {
        flit_label_t            flit_label;
        logic [DATA_WIDTH-1:0]  data;
    } flit_novc_t;

endpackage

// File: rtl/ni_flit_tx_rr_vc_picker.sv
// rtl/ni_flit_tx_rr_vc_picker.sv - combinational round-robin VC search
// Purpose: grant the first requesting VC found scanning from ptr_i+1 (mod VC_NUM).
// Ports: req_i (per-VC request), ptr_i (last granted VC), grant_o (chosen VC), found_o.
module rr_vc_picker
    import noc_params::*;
(
    input  logic [VC_NUM-1:0]  req_i,
    input  logic [VC_SIZE-1:0] ptr_i,
    output logic [VC_SIZE-1:0] grant_o,
    output logic               found_o
);

    function automatic logic [VC_SIZE-1:0] wrap_idx(input logic [VC_SIZE-1:0] p, input int i);
        int s;
        s = (int'(p) + i) % VC_NUM;
        return VC_SIZE'(s);
    endfunction

    // Offset 1 is scanned first so the previous winner has lowest priority.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        for (int i = 1; i <= VC_NUM; i++) begin
            if (!found_o && req_i[wrap_idx(ptr_i, i)]) begin
                found_o = 1'b1;
                grant_o = wrap_idx(ptr_i, i);
            end
        end
    end

endmodule

// File: rtl/ni_flit_tx.sv
// rtl/ni_flit_tx.sv - network-interface flit transmitter with per-packet VC allocation
// Purpose: accept source flits, allocate a free downstream VC per packet, stamp vc_id,
//          drive the router input port under per-VC on/off back-pressure.
// Ports: clk, rst (async active-low); src_flit_i/src_valid_i/src_ready_o (source side);
//        data_o/valid_flit_o (router side, registered); is_on_off_i, is_allocatable_vc_i
//        (downstream per-VC flags); cur_vc_o, busy_o, error_o, pkt_count_o (status).
module ni_flit_tx
    import noc_params::*;
#(
    parameter int HOLDOFF_CYCLES = 2,
    parameter int PKT_CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  flit_novc_t               src_flit_i,
    input  logic                     src_valid_i,
    output logic                     src_ready_o,
    output flit_t                    data_o,
    output logic                     valid_flit_o,
    input  logic [VC_NUM-1:0]        is_on_off_i,
    input  logic [VC_NUM-1:0]        is_allocatable_vc_i,
    output logic [VC_SIZE-1:0]       cur_vc_o,
    output logic                     busy_o,
    output logic                     error_o,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count_o
);

    localparam int HO_W = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                   state_q, state_d;
    flit_t                    data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     error_q, error_d;
    logic [VC_SIZE-1:0]       cur_vc_q, cur_vc_d;
    logic [VC_SIZE-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic [HO_W-1:0]          holdoff_q [VC_NUM];
    logic [HO_W-1:0]          holdoff_d [VC_NUM];

    logic [VC_NUM-1:0]  eligible;
    logic [VC_SIZE-1:0] grant;
    logic               found;
    logic               is_head;
    logic               accept;
    logic               fwd;
    logic               tail_sent;
    logic               violation;
    logic [VC_SIZE-1:0] tx_vc;

    always_comb begin
        eligible = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            eligible[v] = is_allocatable_vc_i[v] && is_on_off_i[v] && (holdoff_q[v] == '0);
        end
    end

    rr_vc_picker u_picker (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .found_o (found)
    );

    assign is_head = (src_flit_i.flit_label == HEAD) || (src_flit_i.flit_label == HEADTAIL);
    assign accept  = src_valid_i && src_ready_o;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && src_flit_i.flit_label == HEAD) state_d = SEND;
            SEND: if (accept && src_flit_i.flit_label == TAIL) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / action decode. src_ready_o never looks at src_valid_i.
    always_comb begin
        src_ready_o = 1'b0;
        fwd         = 1'b0;
        tail_sent   = 1'b0;
        violation   = 1'b0;
        tx_vc       = cur_vc_q;
        case (state_q)
            IDLE: begin
                // Out-of-packet BODY/TAIL is swallowed so the source cannot stall on it.
                src_ready_o = is_head ? found : 1'b1;
                tx_vc       = grant;
                if (accept) begin
                    fwd       = is_head;
                    violation = !is_head;
                    tail_sent = (src_flit_i.flit_label == HEADTAIL);
                end
            end
            SEND: begin
                src_ready_o = is_on_off_i[cur_vc_q];
                if (accept) begin
                    fwd       = !is_head;
                    violation = is_head;
                    tail_sent = (src_flit_i.flit_label == TAIL);
                end
            end
            default: ;
        endcase
    end

    // Datapath next values.
    always_comb begin
        data_d      = data_q;
        valid_d     = fwd;
        error_d     = violation;
        cur_vc_d    = cur_vc_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_count_d = pkt_count_q;
        if (fwd) begin
            data_d.flit_label = src_flit_i.flit_label;
            data_d.data       = src_flit_i.data;
            data_d.vc_id      = tx_vc;
        end
        if (fwd && state_q == IDLE) begin
            cur_vc_d = grant;
            rr_ptr_d = grant;
        end
        if (tail_sent) pkt_count_d = pkt_count_q + 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
            holdoff_d[v] = holdoff_q[v];
            if (tail_sent && VC_SIZE'(v) == tx_vc) begin
                holdoff_d[v] = HO_W'(HOLDOFF_CYCLES);
            end else if (holdoff_q[v] != '0) begin
                holdoff_d[v] = holdoff_q[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            cur_vc_q    <= '0;
            rr_ptr_q    <= VC_SIZE'(VC_NUM - 1);
            pkt_count_q <= '0;
            for (int v = 0; v < VC_NUM; v++) holdoff_q[v] <= '0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            cur_vc_q    <= cur_vc_d;
            rr_ptr_q    <= rr_ptr_d;
            pkt_count_q <= pkt_count_d;
            for (int v = 0; v < VC_NUM; v++) holdoff_q[v] <= holdoff_d[v];
        end
    end

    assign data_o       = data_q;
    assign valid_flit_o = valid_q;
    assign error_o      = error_q;
    assign cur_vc_o     = cur_vc_q;
    assign busy_o       = (state_q == SEND);
    assign pkt_count_o  = pkt_count_q;

endmodule
